// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: registered ARMv8-subset control path (ID/EX, EX/MEM, MEM/WB) with load-use stall and branch flush.
// Defining ILLEGAL_TRAP_EN enables the sticky illegal flag and saturating unknown-opcode counter.
module pipelined_control_unit #(
    parameter int OPC_W    = 11,
    parameter int REG_W    = 5,
    parameter int LINK_REG = 30,
    parameter int ZERO_REG = 31,
    parameter int CNT_W    = 8
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_id_valid,
    input  logic [OPC_W-1:0] i_id_opcode,
    input  logic [REG_W-1:0] i_id_rn,
    input  logic [REG_W-1:0] i_id_rm,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_flush,
    output logic             o_stall,
    output logic [12:0]      o_ex_ctrl,
    output logic [REG_W-1:0] o_ex_rd,
    output logic [12:0]      o_mem_ctrl,
    output logic [REG_W-1:0] o_mem_rd,
    output logic             o_wb_regwrite,
    output logic             o_wb_memtoreg,
    output logic [REG_W-1:0] o_wb_rd,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_illegal_cnt
);
    logic [10:0]      w_op;
    logic [12:0]      w_ctrl;
    logic             w_known;
    logic             w_reads2;
    logic             w_link;
    logic [REG_W-1:0] w_src2;
    logic             w_haz;
    logic             w_bubble;
    logic [12:0]      r_ex_ctrl;
    logic [REG_W-1:0] r_ex_rd;
    logic [12:0]      r_mem_ctrl;
    logic [REG_W-1:0] r_mem_rd;
    logic             r_wb_regwrite;
    logic             r_wb_memtoreg;
    logic [REG_W-1:0] r_wb_rd;

    assign w_op = i_id_opcode[OPC_W-1 -: 11];

    // Exact opcodes are listed before prefixes so the first casez match wins.
    always_comb begin
        w_ctrl   = '0;
        w_known  = 1'b1;
        w_reads2 = 1'b0;
        w_link   = 1'b0;
        casez (w_op)
            11'b10001011000, 11'b11001011000, 11'b10001010000,
            11'b10101010000, 11'b11001010000: begin
                w_ctrl   = 13'b0000000010010;
                w_reads2 = 1'b1;
            end
            11'b11010011011, 11'b11010011010: w_ctrl = 13'b0000000011010;
            11'b11111000010: w_ctrl = 13'b0000001111000;
            11'b11111000000: begin
                w_ctrl   = 13'b0000010001100;
                w_reads2 = 1'b1;
            end
            11'b11010110000: w_ctrl = 13'b0100000000000;
            11'b10110100???: begin
                w_ctrl   = 13'b0000100000101;
                w_reads2 = 1'b1;
            end
            11'b10110101???: begin
                w_ctrl   = 13'b1000100000101;
                w_reads2 = 1'b1;
            end
            11'b100101?????: begin
                w_ctrl = 13'b0011000010000;
                w_link = 1'b1;
            end
            11'b000101?????: w_ctrl = 13'b0001000000000;
            default:         w_known = 1'b0;
        endcase
    end

    assign w_src2   = w_ctrl[2] ? i_id_rt : i_id_rm;
    assign w_haz    = i_id_valid && r_ex_ctrl[6] && r_ex_rd != REG_W'(ZERO_REG) &&
                      (r_ex_rd == i_id_rn || (w_reads2 && r_ex_rd == w_src2));
    assign o_stall  = i_reset_n && !i_flush && w_haz;
    assign w_bubble = i_flush || w_haz || !i_id_valid || !w_known;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_ex_ctrl     <= '0;
            r_ex_rd       <= '0;
            r_mem_ctrl    <= '0;
            r_mem_rd      <= '0;
            r_wb_regwrite <= 1'b0;
            r_wb_memtoreg <= 1'b0;
            r_wb_rd       <= '0;
        end else begin
            r_ex_ctrl     <= w_bubble ? '0 : w_ctrl;
            r_ex_rd       <= w_bubble ? REG_W'(ZERO_REG) : (w_link ? REG_W'(LINK_REG) : i_id_rt);
            r_mem_ctrl    <= i_flush ? '0 : r_ex_ctrl;
            r_mem_rd      <= i_flush ? REG_W'(ZERO_REG) : r_ex_rd;
            r_wb_regwrite <= r_mem_ctrl[4];
            r_wb_memtoreg <= r_mem_ctrl[5];
            r_wb_rd       <= r_mem_rd;
        end
    end

    assign o_ex_ctrl     = r_ex_ctrl;
    assign o_ex_rd       = r_ex_rd;
    assign o_mem_ctrl    = r_mem_ctrl;
    assign o_mem_rd      = r_mem_rd;
    assign o_wb_regwrite = r_wb_regwrite;
    assign o_wb_memtoreg = r_wb_memtoreg;
    assign o_wb_rd       = r_wb_rd;

`ifdef ILLEGAL_TRAP_EN
    logic             r_illegal;
    logic [CNT_W-1:0] r_illegal_cnt;

    // A stalled op is re-presented next cycle, so it is counted only once.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_illegal     <= 1'b0;
            r_illegal_cnt <= '0;
        end else if (i_id_valid && !w_known && !i_flush && !w_haz) begin
            r_illegal     <= 1'b1;
            r_illegal_cnt <= (&r_illegal_cnt) ? r_illegal_cnt : r_illegal_cnt + 1'b1;
        end
    end

    assign o_illegal     = r_illegal;
    assign o_illegal_cnt = r_illegal_cnt;
`else
    assign o_illegal     = 1'b0;
    assign o_illegal_cnt = '0;
`endif
endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb_pipelined_control_unit: directed and random stimulus against a mnemonic-level model, checked by a queue-fed monitor.
module tb_pipelined_control_unit;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_EOR  = 11'b11001010000;
    localparam logic [10:0] OP_LSL  = 11'b11010011011;
    localparam logic [10:0] OP_LSR  = 11'b11010011010;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_BR   = 11'b11010110000;
    localparam int NZ = 12, BRR = 11, BLK = 10, UB = 9, BRC = 8, MW = 7, MR = 6, M2R = 5, RW = 4, AS = 3, R2L = 2;
    localparam int K_UNK = 0, K_R = 1, K_SH = 2, K_LD = 3, K_ST = 4, K_BR = 5, K_CBZ = 6, K_CBNZ = 7, K_BL = 8, K_B = 9;

    typedef struct packed {
        logic [12:0] ctrl;
        logic [4:0]  rd;
    } ent_t;

    typedef struct packed {
        logic       stall;
        ent_t       ex;
        ent_t       mem;
        logic       wr;
        logic       m2r;
        logic [4:0] wrd;
        logic       ill;
        logic [7:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [10:0] id_opcode = '0;
    logic [4:0]  id_rn = '0, id_rm = '0, id_rt = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic [12:0] ex_ctrl, mem_ctrl;
    logic [4:0]  ex_rd, mem_rd, wb_rd;
    logic        wb_regwrite, wb_memtoreg, illegal;
    logic [7:0]  illegal_cnt;

    exp_t q[$];
    ent_t m_ex, m_mem, m_wb;
    logic m_ill;
    logic [7:0] m_cnt;
    logic last_stall;
    int checks = 0, errors = 0;
`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    pipelined_control_unit dut (
        .i_clock(clk), .i_reset_n(reset_n), .i_id_valid(id_valid), .i_id_opcode(id_opcode),
        .i_id_rn(id_rn), .i_id_rm(id_rm), .i_id_rt(id_rt), .i_flush(flush),
        .o_stall(stall), .o_ex_ctrl(ex_ctrl), .o_ex_rd(ex_rd), .o_mem_ctrl(mem_ctrl),
        .o_mem_rd(mem_rd), .o_wb_regwrite(wb_regwrite), .o_wb_memtoreg(wb_memtoreg),
        .o_wb_rd(wb_rd), .o_illegal(illegal), .o_illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    function automatic int kind(input logic [10:0] op);
        if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR || op == OP_EOR) return K_R;
        if (op == OP_LSL || op == OP_LSR) return K_SH;
        if (op == OP_LDUR) return K_LD;
        if (op == OP_STUR) return K_ST;
        if (op == OP_BR) return K_BR;
        if (op[10:3] == 8'b10110100) return K_CBZ;
        if (op[10:3] == 8'b10110101) return K_CBNZ;
        if (op[10:5] == 6'b100101) return K_BL;
        if (op[10:5] == 6'b000101) return K_B;
        return K_UNK;
    endfunction

    function automatic logic [12:0] ctrl_of(input int k);
        logic [12:0] c = '0;
        case (k)
            K_R:    begin c[RW] = 1; c[1:0] = 2'b10; end
            K_SH:   begin c[RW] = 1; c[AS] = 1; c[1:0] = 2'b10; end
            K_LD:   begin c[AS] = 1; c[M2R] = 1; c[RW] = 1; c[MR] = 1; end
            K_ST:   begin c[R2L] = 1; c[AS] = 1; c[MW] = 1; end
            K_BR:   c[BRR] = 1;
            K_CBZ:  begin c[R2L] = 1; c[BRC] = 1; c[1:0] = 2'b01; end
            K_CBNZ: begin c[R2L] = 1; c[BRC] = 1; c[1:0] = 2'b01; c[NZ] = 1; end
            K_BL:   begin c[UB] = 1; c[BLK] = 1; c[RW] = 1; end
            K_B:    c[UB] = 1;
            default: c = '0;
        endcase
        return c;
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, a, x, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("stall", 32'(stall), 32'(e.stall));
            chk("ex_ctrl", 32'(ex_ctrl), 32'(e.ex.ctrl));
            chk("ex_rd", 32'(ex_rd), 32'(e.ex.rd));
            chk("mem_ctrl", 32'(mem_ctrl), 32'(e.mem.ctrl));
            chk("mem_rd", 32'(mem_rd), 32'(e.mem.rd));
            chk("wb_regwrite", 32'(wb_regwrite), 32'(e.wr));
            chk("wb_memtoreg", 32'(wb_memtoreg), 32'(e.m2r));
            chk("wb_rd", 32'(wb_rd), 32'(e.wrd));
            chk("illegal", 32'(illegal), 32'(e.ill));
            chk("illegal_cnt", 32'(illegal_cnt), 32'(e.cnt));
        end
    end

    task automatic step(input logic rstn, input logic v, input logic f, input logic [10:0] op,
                        input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rt);
        exp_t e;
        int k;
        logic st, reads2;
        logic [4:0] s2;
        ent_t bub;
        bub = '{ctrl: 13'd0, rd: 5'd31};
        reset_n = rstn; id_valid = v; flush = f; id_opcode = op; id_rn = rn; id_rm = rm; id_rt = rt;
        k = kind(op);
        reads2 = (k == K_R || k == K_ST || k == K_CBZ || k == K_CBNZ);
        s2 = (k == K_ST || k == K_CBZ || k == K_CBNZ) ? rt : rm;
        st = rstn && !f && v && m_ex.ctrl[MR] && m_ex.rd != 5'd31 && (m_ex.rd == rn || (reads2 && m_ex.rd == s2));
        e.stall = st; e.ex = m_ex; e.mem = m_mem; e.wr = m_wb.ctrl[RW]; e.m2r = m_wb.ctrl[M2R];
        e.wrd = m_wb.rd; e.ill = m_ill; e.cnt = m_cnt;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (!rstn) begin
            m_ex = '0; m_mem = '0; m_wb = '0; m_ill = 0; m_cnt = 0;
        end else begin
            m_wb = m_mem;
            m_mem = f ? bub : m_ex;
            if (f || st || !v || k == K_UNK) m_ex = bub;
            else m_ex = '{ctrl: ctrl_of(k), rd: (k == K_BL) ? 5'd30 : rt};
            if (TRAP && v && k == K_UNK && !f && !st) begin
                m_ill = 1;
                m_cnt = (m_cnt == 8'hFF) ? m_cnt : m_cnt + 8'd1;
            end
        end
        last_stall = st;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, '0, '0, '0, '0);
    endtask

    // Re-presents the instruction while the pipeline holds IF/ID.
    task automatic issue(input logic [10:0] op, input logic [4:0] rn, input logic [4:0] rm,
                         input logic [4:0] rt, input logic f);
        int n = 0;
        do begin
            step(1, 1, f, op, rn, rm, rt);
            n++;
        end while (last_stall && n < 4);
        if (last_stall) chk("stall_bounded", 32'(n), 32'(1));
    endtask

    function automatic logic [4:0] rg();
        int r = $urandom_range(0, 8);
        return (r == 8) ? 5'd31 : 5'(r);
    endfunction

    function automatic logic [10:0] rnd_op();
        case ($urandom_range(0, 16))
            0: return OP_ADD;
            1: return OP_SUB;
            2: return OP_AND;
            3: return OP_ORR;
            4: return OP_EOR;
            5: return OP_LSL;
            6: return OP_LSR;
            7, 8: return OP_LDUR;
            9: return OP_STUR;
            10: return OP_BR;
            11: return {8'b10110100, 3'($urandom)};
            12: return {8'b10110101, 3'($urandom)};
            13: return {6'b100101, 5'($urandom)};
            14: return {6'b000101, 5'($urandom)};
            15: return 11'($urandom);
            default: return 11'd0;
        endcase
    endfunction

    initial begin
        logic [10:0] op;
        logic [4:0] rn, rm, rt;
        logic f;
        m_ex = '0; m_mem = '0; m_wb = '0; m_ill = 0; m_cnt = 0; last_stall = 0;
        repeat (2) @(posedge clk);
        #1;
        step(0, 0, 0, '0, '0, '0, '0);
        issue(OP_ADD, 5'd1, 5'd2, 5'd3, 0);
        idle(3);
        issue(OP_LDUR, 5'd1, 5'd0, 5'd5, 0);
        issue(OP_ADD, 5'd5, 5'd6, 5'd7, 0);
        idle(3);
        issue(OP_LDUR, 5'd1, 5'd0, 5'd31, 0);
        issue(OP_ADD, 5'd31, 5'd31, 5'd4, 0);
        idle(3);
        issue(OP_LDUR, 5'd1, 5'd0, 5'd2, 0);
        issue(OP_STUR, 5'd0, 5'd0, 5'd2, 0);
        idle(2);
        issue(OP_LDUR, 5'd1, 5'd0, 5'd2, 0);
        issue(OP_STUR, 5'd0, 5'd0, 5'd2, 1);
        idle(3);
        issue(11'b10010100110, 5'd0, 5'd0, 5'd9, 0);
        idle(1);
        step(1, 0, 1, '0, '0, '0, '0);
        idle(3);
        repeat (3) issue(11'd0, 5'd1, 5'd2, 5'd3, 0);
        issue(OP_ADD, 5'd1, 5'd2, 5'd3, 0);
        issue(OP_LDUR, 5'd1, 5'd2, 5'd4, 0);
        step(0, 1, 0, OP_ADD, 5'd4, 5'd4, 5'd4);
        idle(2);
        for (int i = 0; i < 3000; i++) begin
            if (!last_stall) begin
                op = rnd_op(); rn = rg(); rm = rg(); rt = rg();
            end
            f = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 99) == 0) step(0, 1, f, op, rn, rm, rt);
            else step(1, ($urandom_range(0, 5) != 0), f, op, rn, rm, rt);
        end
        step(0, 0, 0, '0, '0, '0, '0);
        for (int i = 0; i < 260; i++) step(1, 1, 0, 11'd0, rg(), rg(), rg());
        idle(2);
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
